// File: rtl/fifo_arb_pkg.sv
// Shared types and field positions for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    // owner output layout: {locked, id}
    localparam int OWNER_ID_BIT   = 0;
    localparam int OWNER_LOCK_BIT = 1;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes to rr_ptr.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic       sel,
    output logic       any
);

    assign any = |valid;
    assign sel = (valid == 2'b11) ? rr_ptr : valid[1];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the two-slot FIFO write port between two producers using round-robin
// arbitration, optional locked bursts and per-producer accepted-word counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid0,
    input  logic                    lock0,
    input  logic [2*DATA_WIDTH-1:0] data0,
    output logic                    ready0,
    input  logic                    valid1,
    input  logic                    lock1,
    input  logic [2*DATA_WIDTH-1:0] data1,
    output logic                    ready1,
    input  logic                    full,
    input  logic                    one_left,
    output logic                    wr,
    output logic [DATA_WIDTH-1:0]   w_data0,
    output logic [DATA_WIDTH-1:0]   w_data1,
    output logic [1:0]              owner,
    output logic [CNT_WIDTH-1:0]    acc_cnt0,
    output logic [CNT_WIDTH-1:0]    acc_cnt1
);

    localparam int                 BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam bit                 CAN_LOCK   = (MAX_BURST > 1);

    arb_state_t         state;
    logic               rr_ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic [1:0]         owner_q;

    logic pick_sel, pick_any;
    logic sel_any, sel_id, valid_sel, lock_sel, space, accept;

    rr_pick2 u_pick (
        .valid  ({valid1, valid0}),
        .rr_ptr (rr_ptr),
        .sel    (pick_sel),
        .any    (pick_any)
    );

    // While a lock is held the owner stays selected even with valid low (packet gap).
    always_comb begin
        sel_any = pick_any;
        sel_id  = pick_sel;
        case (state)
            OWN0: begin
                sel_any = 1'b1;
                sel_id  = 1'b0;
            end
            OWN1: begin
                sel_any = 1'b1;
                sel_id  = 1'b1;
            end
            default: ;
        endcase
    end

    // A word occupies two slots and reads are invisible here, so one_left already blocks.
    assign space     = ~full & ~one_left;
    assign valid_sel = sel_id ? valid1 : valid0;
    assign lock_sel  = sel_id ? lock1 : lock0;
    assign accept    = reset & sel_any & valid_sel & space;
    assign ready0    = reset & sel_any & ~sel_id & space;
    assign ready1    = reset & sel_any & sel_id & space;
    assign wr        = accept;
    assign {w_data1, w_data0} = (accept & sel_id) ? data1 : data0;
    assign owner     = owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            owner_q   <= 2'b00;
            acc_cnt0  <= '0;
            acc_cnt1  <= '0;
        end else begin
            if (accept) begin
                if (sel_id) acc_cnt1 <= acc_cnt1 + 1'b1;
                else        acc_cnt0 <= acc_cnt0 + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        burst_cnt              <= BURST_W'(1);
                        owner_q[OWNER_ID_BIT]  <= sel_id;
                        if (lock_sel && CAN_LOCK) begin
                            state                   <= sel_id ? OWN1 : OWN0;
                            owner_q[OWNER_LOCK_BIT] <= 1'b1;
                        end else begin
                            rr_ptr                  <= ~sel_id;
                            owner_q[OWNER_LOCK_BIT] <= 1'b0;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (accept) begin
                        if (!lock_sel || burst_cnt == BURST_LAST) begin
                            state                   <= IDLE;
                            rr_ptr                  <= ~sel_id;
                            burst_cnt               <= '0;
                            owner_q[OWNER_LOCK_BIT] <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (!valid_sel && !lock_sel) begin
                        state                   <= IDLE;
                        rr_ptr                  <= ~sel_id;
                        burst_cnt               <= '0;
                        owner_q[OWNER_LOCK_BIT] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter: round-robin, bursts, space gating, reset and counter wrap.
module tb_fifo_wr_arbiter;

    localparam logic [15:0] DA = 16'hA1A0;
    localparam logic [15:0] DB = 16'hB1B0;

    logic        clk, reset;
    logic        valid0, lock0, valid1, lock1, full, one_left;
    logic [15:0] data0, data1;
    logic        ready0, ready1, wr;
    logic [7:0]  w_data0, w_data1;
    logic [1:0]  owner;
    logic [15:0] acc_cnt0, acc_cnt1;

    logic        w_ready0, w_ready1, w_wr;
    logic [7:0]  w_wd0, w_wd1;
    logic [1:0]  w_owner;
    logic [3:0]  w_acc0, w_acc1;

    int checks = 0;
    int failures = 0;

    fifo_wr_arbiter dut (
        .clk(clk), .reset(reset),
        .valid0(valid0), .lock0(lock0), .data0(data0), .ready0(ready0),
        .valid1(valid1), .lock1(lock1), .data1(data1), .ready1(ready1),
        .full(full), .one_left(one_left), .wr(wr),
        .w_data0(w_data0), .w_data1(w_data1), .owner(owner),
        .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
    );

    fifo_wr_arbiter #(.CNT_WIDTH(4)) dut_w (
        .clk(clk), .reset(reset),
        .valid0(valid0), .lock0(lock0), .data0(data0), .ready0(w_ready0),
        .valid1(valid1), .lock1(lock1), .data1(data1), .ready1(w_ready1),
        .full(full), .one_left(one_left), .wr(w_wr),
        .w_data0(w_wd0), .w_data1(w_wd1), .owner(w_owner),
        .acc_cnt0(w_acc0), .acc_cnt1(w_acc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0, l0;
        logic [15:0] d0;
        logic        v1, l1;
        logic        fl, ol;
        logic        r0, r1, w;
        logic [15:0] wd;
        logic [1:0]  own;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic v0, input logic l0, input logic [15:0] d0,
                                input logic v1, input logic l1, input logic fl, input logic ol,
                                input logic r0, input logic r1, input logic w,
                                input logic [15:0] wd, input logic [1:0] own);
        vec_t v;
        v.v0 = v0; v.l0 = l0; v.d0 = d0; v.v1 = v1; v.l1 = l1; v.fl = fl; v.ol = ol;
        v.r0 = r0; v.r1 = r1; v.w = w; v.wd = wd; v.own = own;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        valid0 = v.v0; lock0 = v.l0; data0 = v.d0;
        valid1 = v.v1; lock1 = v.l1; data1 = DB;
        full = v.fl; one_left = v.ol;
    endtask

    initial begin
        reset = 1'b0;
        valid0 = 0; lock0 = 0; data0 = DA; valid1 = 0; lock1 = 0; data1 = DB;
        full = 0; one_left = 0;

        //         v0 l0 d0       v1 l1 fl ol  r0 r1 wr wd     owner (after edge)
        vecs[0]  = mk(1, 0, DA,      1, 0, 0, 0,  1, 0, 1, DA,      2'b00);
        vecs[1]  = mk(1, 0, DA,      1, 0, 0, 0,  0, 1, 1, DB,      2'b01);
        vecs[2]  = mk(1, 0, DA,      1, 0, 0, 0,  1, 0, 1, DA,      2'b00);
        vecs[3]  = mk(1, 0, DA,      1, 0, 0, 0,  0, 1, 1, DB,      2'b01);
        vecs[4]  = mk(1, 0, DA,      1, 0, 0, 1,  0, 0, 0, DA,      2'b01);
        vecs[5]  = mk(1, 0, DA,      1, 0, 1, 0,  0, 0, 0, DA,      2'b01);
        vecs[6]  = mk(1, 0, DA,      1, 0, 0, 0,  1, 0, 1, DA,      2'b00);
        vecs[7]  = mk(1, 0, DA,      1, 1, 0, 0,  0, 1, 1, DB,      2'b11);
        vecs[8]  = mk(1, 0, DA,      1, 1, 0, 0,  0, 1, 1, DB,      2'b11);
        vecs[9]  = mk(1, 0, DA,      1, 1, 0, 0,  0, 1, 1, DB,      2'b11);
        vecs[10] = mk(1, 0, DA,      1, 1, 0, 0,  0, 1, 1, DB,      2'b01);
        vecs[11] = mk(1, 0, DA,      1, 1, 0, 0,  1, 0, 1, DA,      2'b00);
        vecs[12] = mk(1, 1, DA,      0, 0, 0, 0,  1, 0, 1, DA,      2'b10);
        vecs[13] = mk(0, 1, DA,      1, 0, 0, 0,  1, 0, 0, DA,      2'b10);
        vecs[14] = mk(0, 1, DA,      1, 0, 0, 0,  1, 0, 0, DA,      2'b10);
        vecs[15] = mk(0, 1, DA,      1, 0, 0, 0,  1, 0, 0, DA,      2'b10);
        vecs[16] = mk(0, 0, DA,      1, 0, 0, 0,  1, 0, 0, DA,      2'b00);
        vecs[17] = mk(0, 0, DA,      1, 0, 0, 0,  0, 1, 1, DB,      2'b01);
        vecs[18] = mk(0, 0, DA,      1, 0, 0, 0,  0, 1, 1, DB,      2'b01);
        vecs[19] = mk(1, 0, 16'h1234, 0, 0, 0, 0, 1, 0, 1, 16'h1234, 2'b00);
        vecs[20] = mk(0, 0, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 16'h1234, 2'b00);

        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check_output("rst_ready0", ready0, 0);
        check_output("rst_ready1", ready1, 0);
        check_output("rst_wr", wr, 0);
        check_output("rst_owner", owner, 0);
        check_output("rst_acc0", acc_cnt0, 0);
        check_output("rst_acc1", acc_cnt1, 0);

        for (int i = 0; i < 21; i++) begin
            apply_stimulus(vecs[i]);
            #2;
            check_output($sformatf("v%0d_ready0", i), ready0, vecs[i].r0);
            check_output($sformatf("v%0d_ready1", i), ready1, vecs[i].r1);
            check_output($sformatf("v%0d_wr", i), wr, vecs[i].w);
            check_output($sformatf("v%0d_wdata", i), {w_data1, w_data0}, vecs[i].wd);
            @(posedge clk); #1;
            check_output($sformatf("v%0d_owner", i), owner, vecs[i].own);
        end
        check_output("tbl_acc0", acc_cnt0, 6);
        check_output("tbl_acc1", acc_cnt1, 8);
        check_output("tbl_acc0_w4", w_acc0, 6);
        check_output("tbl_acc1_w4", w_acc1, 8);

        // Start a locked burst from producer 0, then drop reset between clock edges.
        valid0 = 1; lock0 = 1; data0 = 16'hC3C2; valid1 = 0; lock1 = 0;
        @(posedge clk); #1;
        check_output("pre_rst_owner", owner, 2'b10);
        #1 reset = 1'b0;
        #1;
        check_output("mid_rst_owner", owner, 0);
        check_output("mid_rst_wr", wr, 0);
        check_output("mid_rst_ready0", ready0, 0);
        check_output("mid_rst_acc0", acc_cnt0, 0);
        @(negedge clk);
        reset = 1'b1;
        lock0 = 1'b0;
        repeat (17) @(posedge clk);
        #1 valid0 = 1'b0;
        check_output("wrap_acc0_w4", w_acc0, 1);
        check_output("wrap_acc0", acc_cnt0, 17);
        check_output("wrap_acc1", acc_cnt1, 0);
        check_output("wrap_owner", owner, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
